// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard logic and the ID/EX register.
package hazard_detection_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       hilo_write;
    logic [3:0] alu_op;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_BUBBLE = '0;

  // $0 is hard-wired, so a write to it can never create a dependency.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt,
                                     input logic                  uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_mult_busy_counter.sv
// Tracks how long HI/LO stays pending after a MULT/DIV issues to EX.
module mult_busy_counter #(
  parameter int MULT_LATENCY = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Issue,
  output logic Busy
);

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (Issue) begin
      cnt_d = CNT_W'(MULT_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign Busy = busy_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: stalls PC/IF-ID and bubbles ID/EX on hazards forwarding cannot cover.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [REG_ADDR_W-1:0]  Rs_Id,
  input  logic [REG_ADDR_W-1:0]  Rt_Id,
  input  logic                   UsesRt_Id,
  input  logic                   Branch_Id,
  input  logic                   BranchTaken_Id,
  input  logic                   MultStart_Id,
  input  logic                   UsesHiLo_Id,
  input  logic [REG_ADDR_W-1:0]  Rd_Ex,
  input  logic                   RegWrite_Ex,
  input  logic                   MemRead_Ex,
  input  logic [REG_ADDR_W-1:0]  Rd_Mem,
  input  logic                   MemRead_Mem,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IDEXFlush,
  output logic                   IFIDFlush,
  output logic                   Stall,
  output logic                   MultBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic load_use_s, br_ex_s, br_load_s, hilo_s, stall_s, issue_s, mult_busy_s;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign load_use_s = MemRead_Ex && src_match(Rd_Ex, Rs_Id, Rt_Id, UsesRt_Id);
  assign br_ex_s    = Branch_Id && RegWrite_Ex && src_match(Rd_Ex, Rs_Id, Rt_Id, UsesRt_Id);
  assign br_load_s  = Branch_Id && MemRead_Mem && src_match(Rd_Mem, Rs_Id, Rt_Id, UsesRt_Id);
  assign hilo_s     = mult_busy_s && (UsesHiLo_Id || MultStart_Id);
  assign stall_s    = Rst_n && (load_use_s || br_ex_s || br_load_s || hilo_s);
  assign issue_s    = MultStart_Id && !stall_s;

  mult_busy_counter #(
    .MULT_LATENCY(MULT_LATENCY)
  ) u_mult_busy (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Issue(issue_s),
    .Busy (mult_busy_s)
  );

  // While in reset the pipeline is frozen and IF/ID is held at a NOP; a taken
  // branch is only squashed once it is released from any stall.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IDEXFlush = 1'b0;
    IFIDFlush = 1'b0;
    if (!Rst_n) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
      IFIDFlush = 1'b1;
    end else if (stall_s) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
      IFIDFlush = 1'b0;
    end else begin
      IFIDFlush = BranchTaken_Id && Branch_Id;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall      = stall_s;
  assign MultBusy   = mult_busy_s;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit (MULT_LATENCY=4, 3-bit stall counter).
module tb_hazard_detection_unit;

  localparam int LAT = 4;
  localparam int SCW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4:0]     rs, rt, rd_ex, rd_mem;
  logic           uses_rt, br, taken, mstart, hilo, rw_ex, mr_ex, mr_mem;
  logic           pcw, ifidw, idexf, ifidf, stall, busy;
  logic [SCW-1:0] sc;

  typedef struct packed {
    logic [4:0]     ctrl;
    logic           busy;
    logic [SCW-1:0] sc;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt    = 0;
  int   m_sc     = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.MULT_LATENCY(LAT), .STALL_CNT_W(SCW)) dut (
    .Clk(clk), .Rst_n(rst_n), .Rs_Id(rs), .Rt_Id(rt), .UsesRt_Id(uses_rt),
    .Branch_Id(br), .BranchTaken_Id(taken), .MultStart_Id(mstart),
    .UsesHiLo_Id(hilo), .Rd_Ex(rd_ex), .RegWrite_Ex(rw_ex), .MemRead_Ex(mr_ex),
    .Rd_Mem(rd_mem), .MemRead_Mem(mr_mem), .PCWrite(pcw), .IFIDWrite(ifidw),
    .IDEXFlush(idexf), .IFIDFlush(ifidf), .Stall(stall), .MultBusy(busy),
    .StallCount(sc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic dep(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (r == rs) return 1'b1;
    return uses_rt && (r == rt);
  endfunction

  function automatic logic model_stall();
    logic hz;
    hz = 1'b0;
    if (mr_ex && dep(rd_ex)) hz = 1'b1;
    if (br && rw_ex && dep(rd_ex)) hz = 1'b1;
    if (br && mr_mem && dep(rd_mem)) hz = 1'b1;
    if ((m_cnt != 0) && (hilo || mstart)) hz = 1'b1;
    return hz;
  endfunction

  task automatic set_idle();
    rs = 5'd0; rt = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
    uses_rt = 1'b0; br = 1'b0; taken = 1'b0; mstart = 1'b0; hilo = 1'b0;
    rw_ex = 1'b0; mr_ex = 1'b0; mr_mem = 1'b0;
  endtask

  // Inputs are already applied (posedge+1); push expectation, compare at negedge, advance model.
  task automatic run_cycle(input string tag);
    exp_t e, o;
    logic s;
    #1;
    if (!rst_n) begin
      m_cnt = 0;
      m_sc  = 0;
    end
    s = rst_n && model_stall();
    if (!rst_n)  e.ctrl = 5'b00110;
    else if (s)  e.ctrl = 5'b00101;
    else         e.ctrl = {3'b110, br & taken, 1'b0};
    e.busy = (m_cnt != 0);
    e.sc   = SCW'(m_sc);
    q_exp.push_back(e);
    @(negedge clk);
    e = q_exp.pop_front();
    o.ctrl = {pcw, ifidw, idexf, ifidf, stall};
    o.busy = busy;
    o.sc   = sc;
    check_eq({tag, ".ctrl"}, 32'(o.ctrl), 32'(e.ctrl));
    check_eq({tag, ".busy"}, 32'(o.busy), 32'(e.busy));
    check_eq({tag, ".cnt"},  32'(o.sc),   32'(e.sc));
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0;
      m_sc  = 0;
    end else begin
      if (mstart && !s)  m_cnt = LAT;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (s && m_sc < (1 << SCW) - 1) m_sc = m_sc + 1;
    end
    #1;
  endtask

  task automatic reset_dut();
    set_idle();
    rst_n = 1'b0;
    mr_ex = 1'b1; rd_ex = 5'd3; rs = 5'd3;
    run_cycle("rst");
    set_idle();
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    run_cycle("por");
    rst_n = 1'b1;

    // load-use, then the consumer proceeds
    mr_ex = 1'b1; rw_ex = 1'b1; rd_ex = 5'd8; rs = 5'd8;
    run_cycle("lu0");
    set_idle(); mr_mem = 1'b1; rd_mem = 5'd8; rs = 5'd8;
    run_cycle("lu1");
    check_eq("lu_count", 32'(sc), 32'd1);

    // no dependency through $0 or an rt that is not read
    set_idle(); mr_ex = 1'b1; rd_ex = 5'd0; rs = 5'd0;
    run_cycle("zero");
    set_idle(); mr_ex = 1'b1; rd_ex = 5'd9; rt = 5'd9; uses_rt = 1'b0;
    run_cycle("rt_unused");
    uses_rt = 1'b1;
    run_cycle("rt_used");

    // branch after ALU op
    reset_dut();
    rw_ex = 1'b1; rd_ex = 5'd5; br = 1'b1; taken = 1'b1; rs = 5'd5;
    run_cycle("bex0");
    set_idle(); rd_mem = 5'd5; br = 1'b1; taken = 1'b1; rs = 5'd5;
    run_cycle("bex1");

    // branch after load: two stall cycles
    reset_dut();
    mr_ex = 1'b1; rw_ex = 1'b1; rd_ex = 5'd5; br = 1'b1; taken = 1'b1; rs = 5'd5;
    run_cycle("bld0");
    set_idle(); mr_mem = 1'b1; rd_mem = 5'd5; br = 1'b1; taken = 1'b1; rs = 5'd5;
    run_cycle("bld1");
    set_idle(); br = 1'b1; taken = 1'b0; rs = 5'd5; uses_rt = 1'b1; rt = 5'd5;
    run_cycle("bld2");
    check_eq("bld_count", 32'(sc), 32'd2);

    // multiply window, second MULT and MFHI held off
    reset_dut();
    mstart = 1'b1;
    run_cycle("mul_issue");
    check_eq("mul_busy_rise", 32'(busy), 32'd1);
    run_cycle("mul_again");
    mstart = 1'b0; hilo = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle("mfhi");
    check_eq("mul_busy_fall", 32'(busy), 32'd0);

    // reset in the middle of a busy window
    reset_dut();
    mstart = 1'b1;
    run_cycle("rmb_issue");
    set_idle(); hilo = 1'b1;
    run_cycle("rmb_b1");
    run_cycle("rmb_b2");
    rst_n = 1'b0;
    #1;
    check_eq("rmb_busy", 32'(busy), 32'd0);
    check_eq("rmb_ctrl", 32'({pcw, ifidw, idexf, ifidf, stall}), 32'(5'b00110));
    m_cnt = 0;
    m_sc  = 0;
    run_cycle("rmb_hold");
    rst_n = 1'b1;
    run_cycle("rmb_after");

    // stall counter saturation
    reset_dut();
    mr_ex = 1'b1; rd_ex = 5'd12; rs = 5'd12;
    for (int i = 0; i < 10; i++) run_cycle("sat");
    check_eq("sat_count", 32'(sc), 32'd7);
    set_idle();
    run_cycle("sat_idle");

    if (q_exp.size() != 0) check_eq("sb_drain", 32'(q_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
